tm1638_driver: RTL and testbench



---
 rtl/tm1638_driver.sv | 107 ++++++++++
 tb/tb_tm1638_driver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_driver.sv
// tm1638_driver: byte-level serial engine for the TM1638 CLK/DIO pair.
// Shifts one byte out on DIO, or clocks one byte in from DIO, LSB first, per latch request.
// sclk idles high. Each bit is one low half followed by one high half of HALF_PERIOD clk cycles.
//
//   state | meaning
//   IDLE  | bus idle, sclk=1, dio=1, waiting for data_latch_i
//   SHIFT | transferring bit bit_idx_q; phase_q selects low/high half of sclk
module tm1638_driver #(
  parameter int HALF_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_latch_i,
  input  logic       rw_i,
  inout  wire  [7:0] data_io,
  output logic       busy_o,
  output logic       sclk_o,
  input  logic       dio_i,
  output logic       dio_o
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] HP_LOAD = CW'(HALF_PERIOD - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q;
  logic [7:0]    sr_q;
  logic [2:0]    bit_idx_q;
  logic [CW-1:0] cnt_q;
  logic          phase_q;   // 0 = low half, 1 = high half
  logic          dir_q;     // 1 = write, 0 = read
  logic [7:0]    rdata_q;
  logic          busy_q;
  logic          sclk_q;
  logic          dio_q;

  // Host byte bus: the last read byte is presented whenever the host selects read.
  assign data_io = rw_i ? 8'hzz : rdata_q;

  assign busy_o = busy_q;
  assign sclk_o = sclk_q;
  assign dio_o  = dio_q;

  // Transfer sequencer: down-counter times each sclk half, bit counter walks the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= 8'h00;
      bit_idx_q <= 3'd0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      dir_q     <= 1'b0;
      rdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b1;
      dio_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_latch_i) begin
            state_q   <= SHIFT;
            dir_q     <= rw_i;
            sr_q      <= rw_i ? data_io : 8'h00;
            dio_q     <= rw_i ? data_io[0] : 1'b1;
            busy_q    <= 1'b1;
            sclk_q    <= 1'b0;
            bit_idx_q <= 3'd0;
            phase_q   <= 1'b0;
            cnt_q     <= HP_LOAD;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            cnt_q <= HP_LOAD;
            if (!phase_q) begin
              // End of low half: rising sclk, the device (or this block) samples DIO.
              sclk_q  <= 1'b1;
              phase_q <= 1'b1;
              if (!dir_q) begin
                sr_q[bit_idx_q] <= dio_i;
              end
            end else if (bit_idx_q != 3'd7) begin
              // End of high half: falling sclk, present the next bit while sclk is low.
              bit_idx_q <= bit_idx_q + 3'd1;
              sclk_q    <= 1'b0;
              phase_q   <= 1'b0;
              dio_q     <= dir_q ? sr_q[bit_idx_q + 3'd1] : 1'b1;
            end else begin
              // Last bit done: sclk stays high, bus returns to idle.
              state_q <= IDLE;
              busy_q  <= 1'b0;
              dio_q   <= 1'b1;
              if (!dir_q) begin
                rdata_q <= sr_q;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_driver.sv
// Self-checking bench for tm1638_driver: table of byte transfers plus hand-written
// sequences for held latch and mid-transfer reset. A scoreboard queue holds the
// expected DIO bit at each sclk rise and the expected byte at each read completion.
module tb_tm1638_driver;

  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_latch = 1'b0;
  logic       host_rw = 1'b1;
  logic [7:0] host_data = 8'h00;
  logic       dio_in = 1'b1;
  wire  [7:0] data_bus;
  logic       busy;
  logic       sclk;
  logic       dio_out;

  assign data_bus = host_rw ? host_data : 8'hzz;

  tm1638_driver #(.HALF_PERIOD(HP)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_latch_i (data_latch),
    .rw_i         (host_rw),
    .data_io      (data_bus),
    .busy_o       (busy),
    .sclk_o       (sclk),
    .dio_i        (dio_in),
    .dio_o        (dio_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues
  logic       exp_bits[$];
  logic [7:0] exp_rd[$];
  logic [7:0] last_rd = 8'h00;

  // TM1638 DIO model: presents the next read bit on each sclk fall
  logic [7:0] rd_pat = 8'h00;
  int         rd_bit = 0;
  always @(negedge sclk) begin
    if (rd_bit < 8) begin
      dio_in = rd_pat[rd_bit];
      rd_bit++;
    end
  end

  // Monitor: samples on the falling clk edge, checks sclk timing, DIO bits, busy length and read bytes
  logic mon_en = 1'b0;
  logic prev_sclk = 1'b1;
  logic prev_busy = 1'b0;
  int   run_sclk = 1;
  int   run_busy = 1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (sclk !== prev_sclk) begin
        if (sclk) begin
          chk("sclk_low_time", run_sclk, HP);
          if (exp_bits.size() == 0) begin
            chk("unexpected_sclk_pulse", 1, 0);
          end else begin
            chk("dio_at_rise", dio_out, exp_bits.pop_front());
          end
        end else if (prev_busy) begin
          chk("sclk_high_time", run_sclk, HP);
        end
        run_sclk = 1;
      end else begin
        run_sclk++;
      end
      if (busy !== prev_busy) begin
        if (!busy) begin
          chk("busy_time", run_busy, 16 * HP);
          if (exp_rd.size() != 0) chk("read_data", data_bus, exp_rd.pop_front());
        end
        run_busy = 1;
      end else begin
        run_busy++;
      end
    end else begin
      run_sclk = 1;
      run_busy = 1;
    end
    prev_sclk = sclk;
    prev_busy = busy;
  end

  task automatic push_expect(input logic rw, input logic [7:0] wdata, input logic [7:0] pat);
    for (int i = 0; i < 8; i++) exp_bits.push_back(rw ? wdata[i] : 1'b1);
    if (!rw) begin
      exp_rd.push_back(pat);
      last_rd = pat;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 20 * HP; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, busy, 0);
  endtask

  // One handshake transfer: latch while idle, drop latch once busy is seen
  task automatic do_xfer(input logic rw, input logic [7:0] wdata, input logic [7:0] pat);
    @(negedge clk);
    host_rw    = rw;
    host_data  = wdata;
    rd_pat     = pat;
    rd_bit     = 0;
    data_latch = 1'b1;
    push_expect(rw, wdata, pat);
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_sclk", sclk, 0);
    chk("start_dio", dio_out, rw ? wdata[0] : 1'b1);
    data_latch = 1'b0;
    host_data  = ~wdata;
    wait_idle("xfer_timeout");
    chk("end_sclk", sclk, 1);
    chk("end_dio", dio_out, 1);
    host_rw = 1'b0;
    #1;
    chk("rdata_hold", data_bus, last_rd);
  endtask

  typedef struct {
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] pat;
    logic [7:0] exp_byte;   // write: bits expected on DIO; read: byte expected on data bus
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{rw: 1'b1, wdata: 8'hC0, pat: 8'h00, exp_byte: 8'hC0};
    vecs[1] = '{rw: 1'b0, wdata: 8'h00, pat: 8'hA5, exp_byte: 8'hA5};
    vecs[2] = '{rw: 1'b1, wdata: 8'h40, pat: 8'h00, exp_byte: 8'h40};
    vecs[3] = '{rw: 1'b1, wdata: 8'h8F, pat: 8'hFF, exp_byte: 8'h8F};
    vecs[4] = '{rw: 1'b0, wdata: 8'hFF, pat: 8'h3C, exp_byte: 8'h3C};
    vecs[5] = '{rw: 1'b1, wdata: 8'h01, pat: 8'h00, exp_byte: 8'h01};

    // Reset held for 3 cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    host_rw = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_sclk", sclk, 1);
    chk("reset_dio", dio_out, 1);
    chk("reset_data", data_bus, 8'h00);
    mon_en = 1'b1;

    // Table-driven transfers
    for (int v = 0; v < 6; v++) begin
      do_xfer(vecs[v].rw, vecs[v].rw ? vecs[v].exp_byte : vecs[v].wdata,
              vecs[v].rw ? vecs[v].pat : vecs[v].exp_byte);
    end

    // Held latch: second transfer starts on the first idle edge; mid-transfer data change ignored
    @(negedge clk);
    host_rw    = 1'b1;
    host_data  = 8'h3C;
    data_latch = 1'b1;
    push_expect(1'b1, 8'h3C, 8'h00);
    push_expect(1'b1, 8'hE7, 8'h00);
    @(negedge clk);
    chk("held_start_busy", busy, 1);
    repeat (5 * HP) @(negedge clk);
    host_data = 8'hE7;
    wait_idle("held_first_timeout");
    @(negedge clk);
    chk("held_restart_busy", busy, 1);
    chk("held_restart_sclk", sclk, 0);
    data_latch = 1'b0;
    wait_idle("held_second_timeout");
    @(negedge clk);
    chk("held_no_third", busy, 0);

    // Reset at bit 3 of a write
    @(negedge clk);
    host_rw    = 1'b1;
    host_data  = 8'h5A;
    data_latch = 1'b1;
    push_expect(1'b1, 8'h5A, 8'h00);
    @(negedge clk);
    data_latch = 1'b0;
    for (int n = 0; n < 20 * HP; n++) begin
      if (exp_bits.size() <= 5) break;
      @(negedge clk);
    end
    chk("bit3_reached", exp_bits.size(), 5);
    repeat (HP / 2) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_sclk", sclk, 1);
    chk("abort_dio", dio_out, 1);
    rst = 1'b0;
    exp_bits.delete();
    last_rd = 8'h00;
    host_rw = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    #1;
    chk("abort_rdata", data_bus, 8'h00);
    repeat (4 * HP) @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_sclk", sclk, 1);

    repeat (4) @(negedge clk);
    chk("bits_left", exp_bits.size(), 0);
    chk("reads_left", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
